// File: rtl/mute_sched.sv
// Frame scheduler that launches a convolution CPU job by job and walks the row/column grid.
// Define MUTE_SCHED_WD_EN to add a RUN-state watchdog that aborts a job after WD_CYC cycles.
module mute_sched #(
  parameter int unsigned RST_CYC = 4,
  parameter int unsigned WD_CYC  = 200000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [16:0] frame_rows,
  input  logic [16:0] frame_cols,
  input  logic [16:0] row0,
  input  logic [16:0] col0,
  output logic        cpu_reset,
  output logic [16:0] row,
  output logic [16:0] column,
  input  logic        end_cpu,
  input  logic [16:0] next_row,
  input  logic [16:0] next_column,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] job_count,
  output logic        err
);

  typedef enum logic [2:0] {StIdle, StLoad, StRun, StNext, StDone, StErr} state_e;

  localparam logic [3:0] RstLast = 4'(RST_CYC - 1);

  state_e      state_q;
  logic [1:0]  rst_sync_q;
  logic [16:0] rows_q, cols_q;
  logic [16:0] nr_q, nc_q;
  logic [3:0]  rst_cnt_q;
  logic        end_q;
  logic        end_rise;

`ifdef MUTE_SCHED_WD_EN
  localparam logic [31:0] WdLast = 32'(WD_CYC - 1);
  logic [31:0] wd_cnt_q;
`endif

  assign end_rise = end_cpu & ~end_q;

  // Reset deassertion is synchronized; the FSM only accepts start once this has settled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      cpu_reset  <= 1'b1;
      row        <= '0;
      column     <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      job_count  <= '0;
      err        <= 1'b0;
      end_q      <= 1'b0;
      rows_q     <= '0;
      cols_q     <= '0;
      nr_q       <= '0;
      nc_q       <= '0;
      rst_cnt_q  <= '0;
`ifdef MUTE_SCHED_WD_EN
      wd_cnt_q   <= '0;
`endif
    end else begin
      end_q      <= end_cpu;
      frame_done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          cpu_reset <= 1'b1;
          busy      <= 1'b0;
          if (start && rst_sync_q[1]) begin
            rows_q    <= frame_rows;
            cols_q    <= frame_cols;
            row       <= row0;
            column    <= col0;
            job_count <= '0;
            err       <= 1'b0;
            busy      <= 1'b1;
            rst_cnt_q <= '0;
            // Also covers frame_rows == 0, since row0 >= 0 always holds.
            if (row0 >= frame_rows) begin
              frame_done <= 1'b1;
              state_q    <= StDone;
            end else begin
              state_q <= StLoad;
            end
          end
        end
        StLoad: begin
          cpu_reset <= 1'b1;
          if (rst_cnt_q == RstLast) begin
            cpu_reset <= 1'b0;
            state_q   <= StRun;
`ifdef MUTE_SCHED_WD_EN
            wd_cnt_q  <= '0;
`endif
          end else begin
            rst_cnt_q <= rst_cnt_q + 4'd1;
          end
        end
        StRun: begin
          if (end_rise) begin
            nr_q    <= next_row;
            nc_q    <= next_column;
            state_q <= StNext;
            if (job_count != 16'hFFFF) begin
              job_count <= job_count + 16'd1;
            end
`ifdef MUTE_SCHED_WD_EN
          end else if (wd_cnt_q == WdLast) begin
            err       <= 1'b1;
            busy      <= 1'b0;
            cpu_reset <= 1'b1;
            state_q   <= StErr;
          end else begin
            wd_cnt_q <= wd_cnt_q + 32'd1;
`endif
          end
        end
        StNext: begin
          cpu_reset <= 1'b1;
          if (nr_q == row && nc_q == column) begin
            // CPU proposed no progress; park it rather than loop forever.
            err     <= 1'b1;
            busy    <= 1'b0;
            state_q <= StErr;
          end else if (nr_q >= rows_q) begin
            frame_done <= 1'b1;
            state_q    <= StDone;
          end else begin
            row       <= nr_q;
            column    <= (nc_q >= cols_q) ? 17'd0 : nc_q;
            rst_cnt_q <= '0;
            state_q   <= StLoad;
          end
        end
        StDone: begin
          cpu_reset <= 1'b1;
          busy      <= 1'b0;
          state_q   <= StIdle;
        end
        StErr: begin
          cpu_reset <= 1'b1;
          busy      <= 1'b0;
          state_q   <= StIdle;
        end
        default: begin
          cpu_reset <= 1'b1;
          busy      <= 1'b0;
          state_q   <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: doc/mute_sched.md
MUTE_SCHED -- requirements
Module: mute_sched

Interface
REQ-001 Parameter RST_CYC, default 4, SHALL set the number of cycles cpu_reset is held high per job (1..15).
REQ-002 Parameter WD_CYC, default 200000, SHALL set the watchdog limit in cycles (used only with MUTE_SCHED_WD_EN).
REQ-003 Ports SHALL be:
  clk  in  1  single clock, rising edge
  reset  in  1  asynchronous, active-low
  start  in  1  one-cycle pulse, begins a frame
  frame_rows  in  17  frame height, latched at start
  frame_cols  in  17  frame width, latched at start
  row0  in  17  first job row, latched at start
  col0  in  17  first job column, latched at start
  cpu_reset  out  1  active-high reset/launch to the convolution CPU
  row  out  17  job row to CPU
  column  out  17  job column to CPU
  end_cpu  in  1  CPU job-complete level
  next_row  in  17  CPU-proposed next row
  next_column  in  17  CPU-proposed next column
  busy  out  1  high from accepted start until DONE/ERR exit
  frame_done  out  1  one-cycle pulse at frame completion
  job_count  out  16  jobs completed in the current frame
  err  out  1  sticky watchdog/progress error

Function
REQ-004 States SHALL be IDLE, LOAD, RUN, NEXT, DONE, ERR.
REQ-005 IDLE: start=1 latches frame_rows, frame_cols, row0, col0; row<=row0, column<=col0, job_count<=0, err<=0; go LOAD next cycle. start outside IDLE is ignored.
REQ-006 start with row0>=frame_rows or frame_rows==0 SHALL go directly to DONE (zero jobs).
REQ-007 LOAD: cpu_reset=1 for exactly RST_CYC cycles, row/column stable; then cpu_reset=0 and go RUN.
REQ-008 RUN: a rising edge of end_cpu (end_cpu=1 now, 0 the previous cycle) SHALL capture next_row/next_column, increment job_count (saturating at 16'hFFFF) and go NEXT; a level held high from a prior job SHALL NOT count.
REQ-009 NEXT (one cycle): if captured next_row>=frame_rows go DONE; else if next_column>=frame_cols then row<=next_row, column<=0; else row<=next_row, column<=next_column; then go LOAD.
REQ-010 NEXT: if the captured pair equals the current row/column (no progress), SHALL set err=1 and go ERR.
REQ-011 DONE: frame_done=1 for one cycle, busy=0 in the following cycle, go IDLE; row/column retain last values.
REQ-012 ERR: cpu_reset=1, busy=0, err held until next accepted start or reset; return to IDLE after one cycle.
REQ-013 cpu_reset SHALL be 1 in IDLE, DONE and ERR (CPU parked).
REQ-014 busy SHALL be 1 in LOAD, RUN, NEXT; all outputs registered; start-to-first-cpu_reset-deassert latency = 1+RST_CYC cycles.

Reset
REQ-015 reset low SHALL asynchronously force IDLE, cpu_reset=1, row=0, column=0, busy=0, frame_done=0, job_count=0, err=0, end_cpu edge register=0.
REQ-016 reset asserted mid-frame SHALL abandon the frame without a frame_done pulse; deassertion is synchronized to clk before FSM leaves IDLE.

Configuration
REQ-017 With MUTE_SCHED_WD_EN defined, a cycle counter SHALL clear on entry to RUN and, on reaching WD_CYC without an end_cpu edge, set err=1 and go ERR.
REQ-018 Without MUTE_SCHED_WD_EN, no watchdog counter exists and RUN waits indefinitely; REQ-010 remains active.

Verification
REQ-019 frame 210x240, row0=0, col0=0, model returns next_row=row+30, next_column=column -> 7 jobs, frame_done once, job_count=7.
REQ-020 next_column=300 with frame_cols=240 -> following job issued with column=0, row=next_row.
REQ-021 model holds end_cpu=1 across LOAD, then 0, then 1 -> only one job counted.
REQ-022 model returns next equal to current (row=60,column=0) -> err=1, state ERR, cpu_reset=1, no frame_done.
REQ-023 reset low during RUN of job 3 -> cpu_reset=1, job_count=0, busy=0 immediately, no frame_done; new start then runs normally.
REQ-024 MUTE_SCHED_WD_EN, WD_CYC=100, end_cpu never rises -> err=1 exactly 100 cycles after RUN entry; without macro, busy stays 1.
